// File: rtl/fft_sram_arbiter.sv
// fft_sram_arbiter: shares one external 16-bit SRAM between the header and
// body FFT wrappers. The header path has priority. A streak counter bounds how
// long the body path can be made to wait.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   {hdr,body}_req/we/addr/     single-word request: held with stable fields
//     wdata/be                  until the matching ack
//   {hdr,body}_ack              one-cycle completion pulse
//   {hdr,body}_rdata            read data, held until that requester's next read
//   sram_*                      registered SRAM pins (strobes are active-low)
//   owner                       00 none, 01 header, 10 body
module fft_sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES  = 2,
   parameter int unsigned MAX_HDR_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hdr_req,
   input  logic        hdr_we,
   input  logic [19:0] hdr_addr,
   input  logic [15:0] hdr_wdata,
   input  logic [1:0]  hdr_be,
   output logic        hdr_ack,
   output logic [15:0] hdr_rdata,
   input  logic        body_req,
   input  logic        body_we,
   input  logic [19:0] body_addr,
   input  logic [15:0] body_wdata,
   input  logic [1:0]  body_be,
   output logic        body_ack,
   output logic [15:0] body_rdata,
   output logic [19:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_lb_n,
   output logic        sram_ub_n,
   output logic [1:0]  owner
);

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_HDR  = 2'b01;
   localparam logic [1:0] OWN_BODY = 2'b10;

   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_HDR_STREAK);

   logic [1:0]        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [CNT_W-1:0]  streak, streak_d;
   logic              we_q, we_q_d;
   logic [1:0]        owner_d;
   logic              hdr_ack_d, body_ack_d;
   logic [DATA_W-1:0] hdr_rdata_d, body_rdata_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] dq_out_d;
   logic              dq_oe_d, ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;

   // Grant selection and the muxed request fields of the winner
   logic              body_win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        sel_be;

   // Next-state and next-output logic; every pin is computed one cycle ahead
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      streak_d     = streak;
      we_q_d       = we_q;
      owner_d      = owner;
      hdr_ack_d    = 1'b0;
      body_ack_d   = 1'b0;
      hdr_rdata_d  = hdr_rdata;
      body_rdata_d = body_rdata;
      addr_d       = sram_addr;
      dq_out_d     = sram_dq_out;
      dq_oe_d      = sram_dq_oe;
      ce_n_d       = sram_ce_n;
      oe_n_d       = sram_oe_n;
      we_n_d       = sram_we_n;
      lb_n_d       = sram_lb_n;
      ub_n_d       = sram_ub_n;

      body_win  = body_req && (!hdr_req || (streak == STREAK_MAX));
      sel_we    = body_win ? body_we    : hdr_we;
      sel_addr  = body_win ? body_addr  : hdr_addr;
      sel_wdata = body_win ? body_wdata : hdr_wdata;
      sel_be    = body_win ? body_be    : hdr_be;

      case (state)
         ST_IDLE: begin
            owner_d = OWN_NONE;
            dq_oe_d = 1'b0;
            if (!body_req) streak_d = '0;
            if (hdr_req || body_req) begin
               state_d  = ST_ACCESS;
               cnt_d    = CNT_LOAD;
               we_q_d   = sel_we;
               addr_d   = sel_addr;
               dq_out_d = sel_wdata;
               dq_oe_d  = sel_we;
               ce_n_d   = 1'b0;
               oe_n_d   = sel_we;
               we_n_d   = ~sel_we;
               lb_n_d   = ~sel_be[0];
               ub_n_d   = ~sel_be[1];
               if (body_win) begin
                  owner_d  = OWN_BODY;
                  streak_d = '0;
               end else begin
                  owner_d = OWN_HDR;
                  // Only header grants that leave the body waiting count
                  if (body_req && (streak < STREAK_MAX)) streak_d = streak + CNT_W'(1);
               end
            end
         end
         ST_ACCESS: begin
            if (cnt == '0) begin
               state_d = ST_DONE;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               lb_n_d  = 1'b1;
               ub_n_d  = 1'b1;
               if (owner == OWN_BODY) body_ack_d = 1'b1;
               else                   hdr_ack_d  = 1'b1;
               if (!we_q) begin
                  if (owner == OWN_BODY) body_rdata_d = sram_dq_in;
                  else                   hdr_rdata_d  = sram_dq_in;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         ST_DONE: begin
            // DQ drive held through DONE as write hold; released with the turnaround
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            dq_oe_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            dq_oe_d = 1'b0;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         streak      <= '0;
         we_q        <= 1'b0;
         owner       <= OWN_NONE;
         hdr_ack     <= 1'b0;
         body_ack    <= 1'b0;
         hdr_rdata   <= '0;
         body_rdata  <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         streak      <= streak_d;
         we_q        <= we_q_d;
         owner       <= owner_d;
         hdr_ack     <= hdr_ack_d;
         body_ack    <= body_ack_d;
         hdr_rdata   <= hdr_rdata_d;
         body_rdata  <= body_rdata_d;
         sram_addr   <= addr_d;
         sram_dq_out <= dq_out_d;
         sram_dq_oe  <= dq_oe_d;
         sram_ce_n   <= ce_n_d;
         sram_oe_n   <= oe_n_d;
         sram_we_n   <= we_n_d;
         sram_lb_n   <= lb_n_d;
         sram_ub_n   <= ub_n_d;
      end
   end

endmodule

// File: tb/tb_fft_sram_arbiter.sv
// Directed bench for fft_sram_arbiter (ACCESS_CYCLES=2, MAX_HDR_STREAK=4).
// Inputs are driven and outputs sampled on the falling edge; "cycle N" counts
// rising edges after the request is first presented in IDLE.
module tb_fft_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        hdr_req, hdr_we, body_req, body_we;
   logic [19:0] hdr_addr, body_addr;
   logic [15:0] hdr_wdata, body_wdata;
   logic [1:0]  hdr_be, body_be;
   logic        hdr_ack, body_ack;
   logic [15:0] hdr_rdata, body_rdata;
   logic [19:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
   logic [1:0]  owner;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fft_sram_arbiter #(.ACCESS_CYCLES(2), .MAX_HDR_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .hdr_req(hdr_req), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_wdata(hdr_wdata),
      .hdr_be(hdr_be), .hdr_ack(hdr_ack), .hdr_rdata(hdr_rdata),
      .body_req(body_req), .body_we(body_we), .body_addr(body_addr), .body_wdata(body_wdata),
      .body_be(body_be), .body_ack(body_ack), .body_rdata(body_rdata),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .owner(owner)
   );

   // SRAM model folded onto 16 words (address bits [3:0]); byte-enabled writes
   logic [15:0] mem [16] = '{0: 16'hBEEF, 3: 16'h7777, 15: 16'h5678, default: 16'h0000};
   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0000;
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem[sram_addr[3:0]][7:0]  <= sram_dq_out[7:0];
         if (!sram_ub_n) mem[sram_addr[3:0]][15:8] <= sram_dq_out[15:8];
      end
   end

   logic [4:0] strb;
   assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Step up to 'limit' cycles, recording the first ack cycle of each requester
   // and dropping that requester's req when its ack is seen.
   task automatic run_until(input int limit, output int hc, output int bc);
      hc = -1;
      bc = -1;
      for (int c = 1; c <= limit; c++) begin
         step();
         if (hdr_ack && hc < 0) begin hc = c; hdr_req = 1'b0; end
         if (body_ack && bc < 0) begin bc = c; body_req = 1'b0; end
      end
   endtask

   initial begin
      int hc, bc, n, first_c, last_c, dual, acks_seen;
      logic [9:0] order;

      reset = 1'b1;
      hdr_req = 1'b0; hdr_we = 1'b0; hdr_addr = '0; hdr_wdata = '0; hdr_be = 2'b11;
      body_req = 1'b0; body_we = 1'b0; body_addr = '0; body_wdata = '0; body_be = 2'b11;
      step();
      step();
      // Reset values
      chk("rst_strobes", 32'(strb), 32'h1F);
      chk("rst_dq_oe",   32'(sram_dq_oe), 32'h0);
      chk("rst_owner",   32'(owner), 32'h0);
      chk("rst_acks",    32'({hdr_ack, body_ack}), 32'h0);
      chk("rst_addr",    32'(sram_addr), 32'h0);
      chk("rst_dq_out",  32'(sram_dq_out), 32'h0);
      chk("rst_rdata",   {hdr_rdata, body_rdata}, 32'h0);
      reset = 1'b0;
      step();

      // Single header read of 0x00010
      hdr_req = 1'b1; hdr_we = 1'b0; hdr_addr = 20'h00010; hdr_be = 2'b11;
      step();
      chk("hrd_c1_strobes", 32'(strb), 32'h04);
      chk("hrd_c1_owner",   32'(owner), 32'h1);
      chk("hrd_c1_addr",    32'(sram_addr), 32'h10);
      chk("hrd_c1_acks",    32'({hdr_ack, body_ack}), 32'h0);
      step();
      chk("hrd_c2_strobes", 32'(strb), 32'h04);
      chk("hrd_c2_acks",    32'({hdr_ack, body_ack}), 32'h0);
      step();
      chk("hrd_c3_acks",    32'({hdr_ack, body_ack}), 32'h2);
      chk("hrd_c3_rdata",   32'(hdr_rdata), 32'hBEEF);
      chk("hrd_c3_strobes", 32'(strb), 32'h1F);
      hdr_req = 1'b0;
      step();
      chk("hrd_c4_acks",    32'({hdr_ack, body_ack}), 32'h0);
      chk("hrd_c4_owner",   32'(owner), 32'h0);

      // Body write of 0x1234 to 0xFFFFF, upper byte only
      body_req = 1'b1; body_we = 1'b1; body_addr = 20'hFFFFF; body_wdata = 16'h1234; body_be = 2'b10;
      step();
      chk("bwr_c1_strobes", 32'(strb), 32'h0A);
      chk("bwr_c1_dq_oe",   32'(sram_dq_oe), 32'h1);
      chk("bwr_c1_dq_out",  32'(sram_dq_out), 32'h1234);
      chk("bwr_c1_owner",   32'(owner), 32'h2);
      step();
      chk("bwr_c2_strobes", 32'(strb), 32'h0A);
      step();
      chk("bwr_c3_acks",    32'({hdr_ack, body_ack}), 32'h1);
      chk("bwr_c3_strobes", 32'(strb), 32'h1F);
      chk("bwr_c3_dq_oe",   32'(sram_dq_oe), 32'h1);
      body_req = 1'b0; body_we = 1'b0;
      step();
      chk("bwr_c4_dq_oe",   32'(sram_dq_oe), 32'h0);
      chk("bwr_mem",        32'(mem[15]), 32'h1278);
      chk("bwr_hdr_rdata_held", 32'(hdr_rdata), 32'hBEEF);

      // Simultaneous requests: header first, body ACCESS_CYCLES+2 later
      hdr_req = 1'b1; hdr_we = 1'b0; hdr_addr = 20'h00010; hdr_be = 2'b11;
      body_req = 1'b1; body_we = 1'b0; body_addr = 20'hFFFFF; body_be = 2'b11;
      run_until(12, hc, bc);
      chk("sim_hdr_ack_cycle",  32'(hc), 32'd3);
      chk("sim_body_ack_cycle", 32'(bc), 32'd7);
      chk("sim_body_rdata",     32'(body_rdata), 32'h1278);

      // Starvation bound: both requesting continuously for 10 accesses
      hdr_req = 1'b1; body_req = 1'b1;
      n = 0; first_c = -1; last_c = -1; dual = 0; order = '0;
      for (int c = 1; c <= 100 && n < 10; c++) begin
         step();
         if (hdr_ack && body_ack) dual++;
         if (hdr_ack || body_ack) begin
            order[n] = body_ack;
            if (n == 0) first_c = c;
            last_c = c;
            n++;
            if (n == 10) begin hdr_req = 1'b0; body_req = 1'b0; end
         end
      end
      step();
      chk("stv_ack_count",  32'(n), 32'd10);
      chk("stv_order",      32'(order), 32'h210);
      chk("stv_first_ack",  32'(first_c), 32'd3);
      chk("stv_last_ack",   32'(last_c), 32'd39);
      chk("stv_dual_acks",  32'(dual), 32'd0);

      // Reset pulsed in cycle 1 of a header write
      hdr_req = 1'b1; hdr_we = 1'b1; hdr_addr = 20'h00003; hdr_wdata = 16'hDEAD; hdr_be = 2'b11;
      step();
      chk("rsm_c1_strobes", 32'(strb), 32'h08);
      reset = 1'b1;
      #1;
      chk("rsm_async_strobes", 32'(strb), 32'h1F);
      chk("rsm_async_dq_oe",   32'(sram_dq_oe), 32'h0);
      chk("rsm_async_owner",   32'(owner), 32'h0);
      step();
      reset = 1'b0; hdr_req = 1'b0; hdr_we = 1'b0;
      acks_seen = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (hdr_ack || body_ack) acks_seen++;
      end
      chk("rsm_no_ack",       32'(acks_seen), 32'd0);
      chk("rsm_rdata_clear",  32'(hdr_rdata), 32'h0);
      hdr_req = 1'b1; hdr_we = 1'b0; hdr_addr = 20'h00003;
      run_until(6, hc, bc);
      chk("rsm_reissue_ack_cycle", 32'(hc), 32'd3);
      chk("rsm_reissue_rdata",     32'(hdr_rdata), 32'h7777);

      // Read-after-write turnaround on the header path
      hdr_req = 1'b1; hdr_we = 1'b1; hdr_addr = 20'h00005; hdr_wdata = 16'hA5A5; hdr_be = 2'b11;
      step();
      step();
      step();
      chk("raw_wr_ack", 32'(hdr_ack), 32'h1);
      hdr_we = 1'b0;
      step();
      chk("raw_idle_dq_oe",   32'(sram_dq_oe), 32'h0);
      chk("raw_idle_strobes", 32'(strb), 32'h1F);
      chk("raw_idle_owner",   32'(owner), 32'h0);
      step();
      chk("raw_rd_strobes",   32'(strb), 32'h04);
      step();
      step();
      chk("raw_rd_ack",   32'(hdr_ack), 32'h1);
      chk("raw_rd_rdata", 32'(hdr_rdata), 32'hA5A5);
      hdr_req = 1'b0;
      step();

      // be = 00: full-length cycle with both byte strobes inactive, still acked
      body_req = 1'b1; body_we = 1'b0; body_addr = 20'h00010; body_be = 2'b00;
      step();
      chk("be0_c1_strobes", 32'(strb), 32'h07);
      step();
      chk("be0_c2_strobes", 32'(strb), 32'h07);
      step();
      chk("be0_c3_acks", 32'({hdr_ack, body_ack}), 32'h1);
      body_req = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_sram_arbiter.md
# fft_sram_arbiter

Shares the single external 16-bit SRAM between the header FFT wrapper and the body FFT wrapper of the partitioned-convolution reverb. Each wrapper issues single-word read/write requests over a req/ack handshake. The arbiter serialises the requests, drives the SRAM pins with registered timing, and returns read data. The header path is latency-critical and has priority. A streak counter guarantees the body path forward progress.

## Interface

Parameters:
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access (range 1..15)
- MAX_HDR_STREAK, 4, consecutive header grants allowed while body is waiting (range 1..15)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- hdr_req, body_req  in  1  request; held high with fields stable until ack
- hdr_we, body_we  in  1  1 = write, 0 = read
- hdr_addr, body_addr  in  20  word address
- hdr_wdata, body_wdata  in  16  write data
- hdr_be, body_be  in  2  byte enables; bit1 = upper byte, bit0 = lower byte
- hdr_ack, body_ack  out  1  one-cycle completion pulse
- hdr_rdata, body_rdata  out  16  read data; valid in the ack cycle, held until the next read by that requester
- sram_addr  out  20  SRAM address
- sram_dq_out  out  16  write data
- sram_dq_oe  out  1  tristate enable for DQ
- sram_dq_in  in  16  DQ pad input
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1  active-low SRAM strobes
- owner  out  2  current owner: 00 none, 01 header, 10 body

## Operation

- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE → ACCESS:** taken when any req is high. Grant rules:
  - Header wins if hdr_req is set, unless body_req is set and streak == MAX_HDR_STREAK; in that case body wins.
  - Body wins if only body_req is set.
- **Grant registration:** on the transition, the granted address, data, we and be are latched. owner is set accordingly.
- **ACCESS:**
  - Strobes: sram_ce_n = 0. sram_lb_n = ~be[0]. sram_ub_n = ~be[1].
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Write: sram_oe_n = 1, sram_we_n = 0, sram_dq_oe = 1.
  - A down-counter runs from ACCESS_CYCLES-1. Exit to DONE when it reaches 0.
  - On a read, sram_dq_in is captured into the owner's rdata register in the last ACCESS cycle.
- **DONE:**
  - The owner's ack is pulsed for one cycle.
  - All strobes return high. sram_we_n rises in this cycle.
  - sram_dq_oe stays at its ACCESS value for this one cycle (write hold). It drops on entry to IDLE.
  - Next state is always IDLE. The forced IDLE cycle is the bus turnaround.
- **Streak counter (4 bits):**
  - Increments on a header grant while body_req = 1.
  - Clears on any body grant, and on any IDLE cycle with body_req = 0.
  - Saturates at MAX_HDR_STREAK.
- **Requester rule:** after seeing ack, the requester drops req or presents a new request on the following cycle. The IDLE cycle after DONE samples the updated req.
- **Byte enables:** be = 00 still performs a full-length cycle with both byte strobes inactive, and still acks.
- **Reset:**
  - Asynchronous; returns the FSM to IDLE, clears the streak counter and rdata registers, and sets owner = 00.
  - An in-flight access is abandoned with no ack. Requesters re-issue after reset.
- **Protocol violation:** a req dropped before its ack is ignored. The access completes and acks anyway.

## Timing

- **Reset values:**
  - all ack = 0; rdata = 0; owner = 00
  - sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0
- **All outputs are registered:** no combinational path from req to SRAM pins or to ack.
- **Latency:** with req high at cycle 0 in IDLE, ACCESS runs cycles 1..ACCESS_CYCLES, and ack fires at cycle ACCESS_CYCLES+1.
- **Back-to-back throughput:** one access per ACCESS_CYCLES+2 cycles.
- **Simultaneous requests:** the decision is made only in IDLE. Requests arriving during ACCESS or DONE wait.
- **Worst-case body wait:** MAX_HDR_STREAK header accesses followed by its own access.

## Test plan

- **Single header read** (ACCESS_CYCLES = 2, addr 0x00010, SRAM model returns 0xBEEF): ce_n/oe_n low cycles 1-2, hdr_ack at cycle 3, hdr_rdata = 0xBEEF, body_ack never asserts.
- **Body write** of 0x1234 to 0xFFFFF, be = 10: we_n low 2 cycles, ub_n = 0, lb_n = 1, dq_oe high through DONE, low at next IDLE; model upper byte = 0x12, lower byte unchanged.
- **Simultaneous hdr_req and body_req at cycle 0:** header acked first; body acked ACCESS_CYCLES+2 cycles later.
- **Starvation bound** (MAX_HDR_STREAK = 4), both requesters continuously requesting: grant order H,H,H,H,B,H,H,H,H,B; body receives exactly 1 of every 5 acks.
- **Reset mid-ACCESS** (reset pulsed in cycle 1 of a header write): strobes immediately high, dq_oe = 0, no ack; after release, a re-issued read of the same address completes normally in 4 cycles.
- **Read-after-write turnaround** (header writes 0xA5A5 then reads the same address back-to-back): the IDLE cycle between accesses has dq_oe = 0 and all strobes high; the read returns 0xA5A5.
